// File: rtl/instr_loader.sv
// instr_loader: keys instruction words in from an 8-bit DIP switch one byte
// per press of btn_load, queues completed words in a small FIFO and hands
// them to the CPU core over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sw_in[7:0]            switch byte, sampled only on an accepted load edge
//   btn_load, btn_clear   raw asynchronous push buttons
//   instr_data[IW-1:0]    word at the FIFO head (IW = 8*BYTES_PER_INSTR)
//   instr_valid           FIFO non-empty
//   instr_ready           consumer takes the head word this cycle
//   byte_idx              index of the next byte to be loaded
//   fifo_count, fifo_full queue occupancy
//   overflow              sticky: a completed word was dropped (full queue)
//
// Build option: define LOADER_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stable-level
// filter in each button path (press latency 3 + DEBOUNCE_CYCLES instead of 3).

// Generic synchronous FWFT FIFO with flush.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy drops when full unless a read frees a slot that cycle.
module fifo_sync #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    input  logic                   rd_rdy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    logic          vld_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign do_pop  = vld_q & rd_rdy;
    // A full queue still takes a word when the head leaves in the same cycle.
    assign wr_rdy  = ~full | do_pop;
    assign do_push = wr_vld & wr_rdy;

    always_comb begin
        count_nxt = count_q;
        if (do_push && !do_pop) begin
            count_nxt = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
            // Storage is zeroed so the head reads 0 while empty after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_nxt;
            vld_q   <= (count_nxt != '0);
        end
    end

    assign rd_vld = vld_q;
    assign rd_dat = mem[rd_ptr];
    assign count  = count_q;
endmodule

// Byte-wise instruction assembler from switches and buttons into a word queue.
// Latency: button rise to byte commit 3 cycles (+DEBOUNCE_CYCLES if filtered);
// a completed word reaches instr_valid the cycle after its final-byte commit.
// Backpressure: instr_ready pops the head; a word completing into a full queue
// with no same-cycle pop is dropped and flagged on overflow.
module instr_loader #(
    parameter int BYTES_PER_INSTR = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic [7:0]                                             sw_in,
    input  logic                                                   btn_load,
    input  logic                                                   btn_clear,
    output logic [8*BYTES_PER_INSTR-1:0]                           instr_data,
    output logic                                                   instr_valid,
    input  logic                                                   instr_ready,
    output logic [((BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1)-1:0] byte_idx,
    output logic [$clog2(FIFO_DEPTH):0]                            fifo_count,
    output logic                                                   fifo_full,
    output logic                                                   overflow
);
    localparam int IW  = 8 * BYTES_PER_INSTR;
    localparam int BIW = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BYTES_PER_INSTR - 1);

    if (BYTES_PER_INSTR < 1 || BYTES_PER_INSTR > 8) begin : g_bad_bytes
        $error("instr_loader: BYTES_PER_INSTR must be 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_loader: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("instr_loader: DEBOUNCE_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Button paths: [0] = load, [1] = clear.
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic [1:0] settle_cnt;
    logic       settled;

    assign btn_raw = {btn_clear, btn_load};

    // Two cycles after reset release the synchronisers hold real button
    // levels; only from then on may a button be armed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= 2'd0;
        end else if (settle_cnt != 2'd2) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end
    assign settled = (settle_cnt == 2'd2);

`ifdef LOADER_DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
`endif

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic sync1;
        logic sync2;
        logic acc;      // accepted (filtered) level
        logic prev;
        logic armed;

`ifdef LOADER_DEBOUNCE_EN
        logic [DCW-1:0] db_cnt;

        // The counter ticks once per cycle of disagreement; the new level is
        // taken on the DEBOUNCE_CYCLES-th consecutive one.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                db_cnt <= '0;
                acc    <= 1'b0;
            end else if (sync2 == acc) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                acc    <= sync2;
            end else begin
                db_cnt <= db_cnt + DCW'(1);
            end
        end
`else
        assign acc = sync2;
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                prev  <= 1'b0;
                armed <= 1'b0;
            end else begin
                sync1 <= btn_raw[b];
                sync2 <= sync1;
                prev  <= acc;
                // A button held through reset stays disarmed until it has
                // been seen released, so it cannot fire on reset release.
                if (settled && !sync2 && !acc) begin
                    armed <= 1'b1;
                end
            end
        end

        assign btn_pulse[b] = armed & acc & ~prev;
    end

    logic load_pulse;
    logic clear_pulse;
    assign load_pulse  = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic [BIW-1:0] idx_q;
    logic [IW-1:0]  asm_q;
    logic [IW-1:0]  asm_nxt;
    logic           last_byte;
    logic           push_vld;
    logic           push_rdy;
    logic           ovf_q;

    // The final byte is merged combinationally so the complete word can be
    // pushed in the same cycle as its last load edge.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[8*int'(idx_q) +: 8] = sw_in;
    end

    assign last_byte = (idx_q == LAST_IDX);
    // Clear wins over a same-cycle load: that byte never reaches the queue.
    assign push_vld  = load_pulse & last_byte & ~clear_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_pulse) begin
            idx_q <= '0;
            asm_q <= '0;
            ovf_q <= 1'b0;
        end else if (load_pulse) begin
            if (last_byte) begin
                idx_q <= '0;
                asm_q <= '0;
                if (!push_rdy) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                idx_q <= idx_q + BIW'(1);
                asm_q <= asm_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word queue
    // ------------------------------------------------------------------
    fifo_sync #(
        .W     (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clear_pulse),
        .wr_vld (push_vld),
        .wr_dat (asm_nxt),
        .wr_rdy (push_rdy),
        .rd_vld (instr_valid),
        .rd_dat (instr_data),
        .rd_rdy (instr_ready),
        .count  (fifo_count),
        .full   (fifo_full)
    );

    assign byte_idx = idx_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with default parameters; button timing
// follows LOADER_DEBOUNCE_EN so the same bench covers both builds.
module tb_instr_loader;
    localparam int BPI   = 2;
    localparam int DEPTH = 4;
    localparam int DB    = 16;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sw_in = 8'h00;
    logic        btn_load = 1'b0;
    logic        btn_clear = 1'b0;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic        instr_valid;
    logic [0:0]  byte_idx;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_loader #(
        .BYTES_PER_INSTR (BPI),
        .FIFO_DEPTH      (DEPTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .btn_load    (btn_load),
        .btn_clear   (btn_clear),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .byte_idx    (byte_idx),
        .fifo_count  (fifo_count),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    // Raise load; return at the negedge just before the commit edge.
    task automatic load_rise(input logic [7:0] b);
        sw_in    = b;
        btn_load = 1'b1;
        repeat (LAT - 1) @(negedge clk);
    endtask

    // Release load and scramble the switches, which must not matter now.
    task automatic load_release();
        btn_load = 1'b0;
        sw_in    = 8'hEE;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic press_load(input logic [7:0] b);
        load_rise(b);
        @(negedge clk);
        load_release();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        repeat (LAT) @(negedge clk);
        btn_clear = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL rst_idx: got %0d want 0", byte_idx); else n_pass++;
        n_chk++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else n_pass++;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (fifo_full !== 1'b0) $display("FAIL rst_full: got %b want 0", fifo_full); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else n_pass++;
        n_chk++; if (instr_data !== 16'h0000) $display("FAIL rst_data: got %h want 0000", instr_data); else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        press_load(8'h3A);
        n_chk++; if (byte_idx !== 1'b1) $display("FAIL basic_idx1: got %0d want 1", byte_idx); else n_pass++;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", instr_valid); else n_pass++;
        load_rise(8'h5C);
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL basic_valid_pre: got %b want 0", instr_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL basic_idx0: got %0d want 0", byte_idx); else n_pass++;
        n_chk++; if (instr_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", instr_valid); else n_pass++;
        n_chk++; if (instr_data !== 16'h5C3A) $display("FAIL basic_data: got %h want 5c3a", instr_data); else n_pass++;
        n_chk++; if (fifo_count !== 3'd1) $display("FAIL basic_count: got %0d want 1", fifo_count); else n_pass++;
        load_release();
        n_chk++; if (instr_data !== 16'h5C3A) $display("FAIL basic_data_hold: got %h want 5c3a", instr_data); else n_pass++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (fifo_count !== 3'd0) $display("FAIL basic_pop_count: got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0]  b;
        logic [15:0] exp;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            press_load(b);
            press_load(b);
        end
        n_chk++; if (fifo_count !== 3'd4) $display("FAIL ovf_count4: got %0d want 4", fifo_count); else n_pass++;
        n_chk++; if (fifo_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", fifo_full); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_pre: got %b want 0", overflow); else n_pass++;
        press_load(8'h05);
        press_load(8'h05);
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
        n_chk++; if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", fifo_count); else n_pass++;
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL ovf_idx: got %0d want 0", byte_idx); else n_pass++;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b   = 8'(i + 1);
            exp = {b, b};
            n_chk++; if (instr_data !== exp) $display("FAIL ovf_drain%0d: got %h want %h", i, instr_data, exp); else n_pass++;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_clear();
        press_load(8'hA1);
        press_load(8'hB1);
        press_load(8'hA2);
        press_load(8'hB2);
        press_load(8'hAA);
        n_chk++; if (byte_idx !== 1'b1) $display("FAIL clr_pre_idx: got %0d want 1", byte_idx); else n_pass++;
        n_chk++; if (fifo_count !== 3'd2) $display("FAIL clr_pre_count: got %0d want 2", fifo_count); else n_pass++;
        press_clear();
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL clr_idx: got %0d want 0", byte_idx); else n_pass++;
        n_chk++; if (fifo_count !== 3'd0) $display("FAIL clr_count: got %0d want 0", fifo_count); else n_pass++;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL clr_valid: got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", overflow); else n_pass++;
        press_load(8'h11);
        press_load(8'h22);
        n_chk++; if (instr_data !== 16'h2211) $display("FAIL clr_next_data: got %h want 2211", instr_data); else n_pass++;
        n_chk++; if (fifo_count !== 3'd1) $display("FAIL clr_next_count: got %0d want 1", fifo_count); else n_pass++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [7:0]  b;
        logic [15:0] exp;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            press_load(b);
            press_load(b);
        end
        press_load(8'h05);
        load_rise(8'h05);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_chk++; if (fifo_count !== 3'd4) $display("FAIL fp_count: got %0d want 4", fifo_count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL fp_ovf: got %b want 0", overflow); else n_pass++;
        n_chk++; if (fifo_full !== 1'b1) $display("FAIL fp_full: got %b want 1", fifo_full); else n_pass++;
        load_release();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b   = 8'(i + 2);
            exp = {b, b};
            n_chk++; if (instr_data !== exp) $display("FAIL fp_drain%0d: got %h want %h", i, instr_data, exp); else n_pass++;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL fp_empty: got %b want 0", instr_valid); else n_pass++;
    endtask

    // A long press commits exactly LAT edges after the raw rise, and only once.
    task automatic test_latency();
        sw_in    = 8'h77;
        btn_load = 1'b1;
        for (int t = 1; t <= LAT + 21; t++) begin
            @(negedge clk);
            if (t == LAT - 1) begin
                n_chk++; if (byte_idx !== 1'b0) $display("FAIL lat_early: got %0d want 0", byte_idx); else n_pass++;
            end
            if (t == LAT) begin
                n_chk++; if (byte_idx !== 1'b1) $display("FAIL lat_edge: got %0d want 1", byte_idx); else n_pass++;
            end
        end
        load_release();
        repeat (25) @(negedge clk);
        n_chk++; if (byte_idx !== 1'b1) $display("FAIL lat_once: got %0d want 1", byte_idx); else n_pass++;
        n_chk++; if (fifo_count !== 3'd0) $display("FAIL lat_count: got %0d want 0", fifo_count); else n_pass++;
        press_clear();
    endtask

`ifdef LOADER_DEBOUNCE_EN
    task automatic test_glitch();
        sw_in    = 8'h66;
        btn_load = 1'b1;
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        repeat (40) @(negedge clk);
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL glitch_idx: got %0d want 0", byte_idx); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        press_load(8'h44);
        press_load(8'h33);
        press_load(8'h12);
        n_chk++; if (fifo_count !== 3'd1) $display("FAIL rm_pre_count: got %0d want 1", fifo_count); else n_pass++;
        sw_in    = 8'h99;
        btn_load = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL rm_idx: got %0d want 0", byte_idx); else n_pass++;
        n_chk++; if (fifo_count !== 3'd0) $display("FAIL rm_count: got %0d want 0", fifo_count); else n_pass++;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (instr_data !== 16'h0000) $display("FAIL rm_data: got %h want 0000", instr_data); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT + 6) @(negedge clk);
        n_chk++; if (byte_idx !== 1'b0) $display("FAIL rm_held_idx: got %0d want 0", byte_idx); else n_pass++;
        btn_load = 1'b0;
        sw_in    = 8'hEE;
        repeat (LAT + 4) @(negedge clk);
        press_load(8'h55);
        n_chk++; if (byte_idx !== 1'b1) $display("FAIL rm_repress_idx: got %0d want 1", byte_idx); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_clear();
        test_full_pop();
        test_latency();
`ifdef LOADER_DEBOUNCE_EN
        test_glitch();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Parametrised successor to the two-press DIP-switch instruction loader in the top level.
- Assembles BYTES_PER_INSTR bytes from the 8-bit switch bus into one instruction word. Each byte is committed by a debounced, edge-detected push button.
- Completed words go into a first-word-fall-through FIFO. The CPU core drains them with a valid/ready handshake, so several instructions can be keyed in ahead of execution.
- A second button aborts a partial word and flushes the queue.

Parameters:
- BYTES_PER_INSTR, 2: bytes per instruction word. Legal range 1..8. IW = 8*BYTES_PER_INSTR.
- FIFO_DEPTH, 4: number of queued instruction words. Must be a power of 2, at least 2.
- DEBOUNCE_CYCLES, 16: stable-level cycles required before a button change is accepted. Used only with LOADER_DEBOUNCE_EN. Must be at least 1.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous, active-low reset.
- sw_in, input, 8: DIP switch byte, sampled on the accepted load edge.
- btn_load, input, 1: raw load push button (asynchronous).
- btn_clear, input, 1: raw clear push button (asynchronous).
- instr_data, output, IW: instruction word at the FIFO head.
- instr_valid, output, 1: FIFO non-empty.
- instr_ready, input, 1: consumer accepts the head word this cycle.
- byte_idx, output, clog2(BYTES_PER_INSTR) (minimum 1): index of the next byte to load.
- fifo_count, output, clog2(FIFO_DEPTH)+1: number of words queued.
- fifo_full, output, 1: fifo_count == FIFO_DEPTH.
- overflow, output, 1: sticky flag, a completed word was dropped.

Behaviour:
- Reset (rst_n = 0 at posedge clk):
  - Synchronisers, edge registers and debounce counters clear to 0.
  - Assembly register clears to 0; byte_idx = 0.
  - FIFO is emptied; fifo_count = 0, instr_valid = 0, fifo_full = 0, overflow = 0.
  - instr_data = 0 while the FIFO is empty after reset.
- Button path, per button:
  - 2-FF synchroniser, then a previous-level register.
  - Edge pulse = synced level & ~previous level; one cycle wide.
  - Latency from raw rise to edge pulse is 3 cycles.
  - A held button produces exactly one pulse.
- Load edge, with byte_idx = k:
  - sw_in is written to assembly bits [8k+7:8k]. Byte 0 is the least significant, so the first press carries the opcode in bits [3:0].
  - If k < BYTES_PER_INSTR-1: byte_idx increments.
  - If k = BYTES_PER_INSTR-1: the completed word, including the current byte, is pushed in the same cycle. byte_idx returns to 0 and the assembly register clears.
- Push acceptance:
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is discarded, overflow is set to 1, and byte_idx still returns to 0.
- Pop: occurs when instr_valid & instr_ready. The next word appears on instr_data in the following cycle.
- Simultaneous push and pop: fifo_count is unchanged and word order is preserved.
- FIFO pointers wrap modulo FIFO_DEPTH.
- instr_valid = (fifo_count != 0), registered.
- A pushed word becomes visible on instr_data/instr_valid 1 cycle after the final-byte edge.
- instr_ready while empty: no effect.
- Clear edge:
  - Sets byte_idx = 0, clears the assembly register, empties the FIFO and clears overflow.
  - Clear has priority over a same-cycle load edge (that byte is lost) and over a same-cycle pop.
- sw_in is sampled only on the load edge; changes at any other time have no effect.
- Reset mid-word or mid-debounce: the partial word is lost and all state returns to reset values. No pulse is generated by a button already held across reset release until it is released and pressed again.

Optional Feature:
- Macro: LOADER_DEBOUNCE_EN.
- Defined:
  - Per button, a counter runs while the synced level differs from the accepted level. The counter resets whenever the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synced value.
  - The edge pulse is generated on the accepted level's 0->1 transition.
  - Press latency = 3 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Undefined: no counter; the accepted level is the synced level, with the 3-cycle latency stated above. All other behaviour is identical.

Test Plan:
- Defaults, debounce off, instr_ready = 0. Press load with sw_in = 0x3A, then 0x5C. Expect: byte_idx goes 0->1->0; instr_data = 0x5C3A; instr_valid = 1 one cycle after the second edge; fifo_count = 1.
- Queue 4 words 0x0101, 0x0202, 0x0303, 0x0404, then a fifth word 0x0505. Expect: fifo_full = 1, overflow = 1, fifo_count = 4. Raise instr_ready for 4 cycles; expect pops in order 0x0101..0x0404, then instr_valid = 0.
- FIFO full with instr_ready = 1 held as the fifth word's final byte arrives. Expect: push accepted, overflow = 0, fifo_count stays 4, 0x0505 emerges last.
- Load one byte (0xAA), then press clear with two words queued. Expect: byte_idx = 0, fifo_count = 0, instr_valid = 0, overflow = 0. The next two presses (0x11, 0x22) yield 0x2211.
- LOADER_DEBOUNCE_EN, DEBOUNCE_CYCLES = 16. A 10-cycle load pulse produces no byte load. A 40-cycle press loads exactly once, with the edge 19 cycles after the raw rise.
- Assert rst_n = 0 after one byte loaded and one word queued. Expect: all outputs at reset values on the next cycle. A held btn_load across reset release does not load.
